// File: rtl/mul_div_seq_if.sv
// Start/busy/done handshake and operand/result bus of the iterative multiply/divide unit.
interface mul_div_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic [1:0]       op;
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output opA, opB, op, start, input busy, done, hi, lo);
    modport slave  (input opA, opB, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_seq.sv
// Iterative MULTU/MULT/DIVU/DIV unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, sign fix-up at the end, results held in HI/LO until the next completion.
module mul_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    mul_div_seq_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               div_q,    div_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   mag_q,    mag_d;
    logic [2*WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   hi_q,     hi_d;
    logic [WIDTH-1:0]   lo_q,     lo_d;

    // Operand signs and magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign sgn_a = bus.op[0] & bus.opA[WIDTH-1];
    assign sgn_b = bus.op[0] & bus.opB[WIDTH-1];
    assign abs_a = sgn_a ? -bus.opA : bus.opA;
    assign abs_b = sgn_b ? -bus.opB : bus.opB;

    // Multiply step: acc = {partial high, remaining multiplier bits}.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    assign mul_acc = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide step: dividend shifts out of acc MSB-first, quotient bits shift in at the LSB.
    logic [WIDTH:0]       r_shift, div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   div_acc;
    assign r_shift  = {rem_q, acc_q[WIDTH-1]};
    assign div_diff = r_shift - {1'b0, mag_q};
    assign div_ge   = ~div_diff[WIDTH];
    assign div_rem  = div_ge ? div_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
    assign div_acc  = {acc_q[2*WIDTH-2:0], div_ge};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_ITER;
                    cnt_d    = CW'(WIDTH);
                    div_d    = bus.op[1];
                    neg_lo_d = sgn_a ^ sgn_b;
                    neg_hi_d = bus.op[1] ? sgn_a : (sgn_a ^ sgn_b);
                    mag_d    = bus.op[1] ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? abs_a : abs_b)};
                    rem_d    = '0;
                    busy_d   = 1'b1;
                end
            end
            S_ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (div_q) begin
                    acc_d = div_acc;
                    rem_d = div_rem;
                end else begin
                    acc_d = mul_acc;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (div_q) begin
                    lo_d = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_hi_q ? -rem_q : rem_q;
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? -acc_q : acc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            mag_q    <= mag_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mul_div_seq.sv
// Bench for mul_div_seq: directed corner cases plus random operations against an arithmetic model.
module tb_mul_div_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    mul_div_seq_if #(.WIDTH(W)) bus ();

    mul_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference results from plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: p = {32'd0, a} * {32'd0, b};
            2'd1: p = 64'(sa * sb);
            2'd2: begin
                if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
                else            p = {a % b, a / b};
            end
            default: begin
                if (b == 32'd0) begin
                    p = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {32'(r), 32'(q)};
                end
            end
        endcase
        hi = p[63:32];
        lo = p[31:0];
    endfunction

    // Issue one operation (call with start low, just after an edge) and check the result,
    // latency, busy window and HI/LO hold. spur >= 0 pulses a stray start at that busy cycle.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int spur);
        logic [31:0] eh, el, ph, pl;
        int          k, bcnt;
        bit          moved;
        model(op, a, b, eh, el);
        ph = bus.hi;
        pl = bus.lo;
        moved = 1'b0;
        bcnt = 0;
        bus.op = op;
        bus.opA = a;
        bus.opB = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.opA = $urandom;
        bus.opB = $urandom;
        bus.op = 2'($urandom);
        k = 0;
        while (!bus.done && k < 60) begin
            if (bus.busy) bcnt++;
            if (bus.hi !== ph || bus.lo !== pl) moved = 1'b1;
            bus.start = (k == spur);
            if (k == spur) begin
                bus.opA = $urandom;
                bus.opB = $urandom;
            end
            @(posedge clk);
            #1;
            k++;
        end
        bus.start = 1'b0;
        check({tag, ":latency"}, 64'(k), 64'(W + 1));
        check({tag, ":busy_cycles"}, 64'(bcnt), 64'(W + 1));
        check({tag, ":busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, ":hold"}, 64'(moved), 64'd0);
        check({tag, ":hi"}, 64'(bus.hi), 64'(eh));
        check({tag, ":lo"}, 64'(bus.lo), 64'(el));
    endtask

    initial begin
        logic [31:0] corner [6];
        logic [31:0] ra, rb;
        corner[0] = 32'd0;
        corner[1] = 32'd1;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000;
        corner[4] = 32'h7FFF_FFFF;
        corner[5] = 32'd7;

        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.opA = '0;
        bus.opB = '0;
        #3;
        check("rst:busy", 64'(bus.busy), 64'd0);
        check("rst:done", 64'(bus.done), 64'd0);
        check("rst:hi", 64'(bus.hi), 64'd0);
        check("rst:lo", 64'(bus.lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        check("multu_max:hi_const", 64'(bus.hi), 64'hFFFF_FFFE);
        check("multu_max:lo_const", 64'(bus.lo), 64'h1);
        @(posedge clk);
        #1;
        check("done_pulse_width", 64'(bus.done), 64'd0);

        do_op("mult_neg3x5", 2'd1, 32'hFFFF_FFFD, 32'd5, -1);
        check("mult_neg3x5:lo_const", 64'(bus.lo), 64'hFFFF_FFF1);
        do_op("mult_minxmin", 2'd1, 32'h8000_0000, 32'h8000_0000, -1);
        check("mult_minxmin:hi_const", 64'(bus.hi), 64'h4000_0000);
        do_op("divu_100_7", 2'd2, 32'd100, 32'd7, -1);
        check("divu_100_7:lo_const", 64'(bus.lo), 64'd14);
        do_op("div_m7_2", 2'd3, 32'hFFFF_FFF9, 32'd2, -1);
        do_op("div_7_m2", 2'd3, 32'd7, 32'hFFFF_FFFE, -1);
        check("div_7_m2:hi_const", 64'(bus.hi), 64'd1);
        do_op("divu_5_0", 2'd2, 32'd5, 32'd0, -1);
        check("divu_5_0:lo_const", 64'(bus.lo), 64'hFFFF_FFFF);
        do_op("div_m5_0", 2'd3, 32'hFFFF_FFFB, 32'd0, -1);
        check("div_m5_0:lo_const", 64'(bus.lo), 64'd1);
        do_op("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        check("div_min_m1:lo_const", 64'(bus.lo), 64'h8000_0000);

        // Stray start while busy must be ignored.
        repeat (3) @(posedge clk);
        #1;
        do_op("spur_start", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        @(posedge clk);
        #1;
        check("spur_start:no_relaunch", 64'(bus.busy), 64'd0);

        // Back-to-back: second op launched from the done cycle of the first.
        do_op("b2b_first", 2'd1, 32'hDEAD_BEEF, 32'd12345, -1);
        do_op("b2b_second", 2'd3, 32'hDEAD_BEEF, 32'd12345, -1);

        // Asynchronous reset in the middle of an operation.
        bus.op = 2'd0;
        bus.opA = 32'hFFFF_0000;
        bus.opB = 32'h0000_FFFF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst:busy", 64'(bus.busy), 64'd0);
        check("midrst:done", 64'(bus.done), 64'd0);
        check("midrst:hi", 64'(bus.hi), 64'd0);
        check("midrst:lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        do_op("post_rst_6x7", 2'd0, 32'd6, 32'd7, -1);
        check("post_rst_6x7:lo_const", 64'(bus.lo), 64'd42);

        // Random operations, operands occasionally drawn from corner values.
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(16, 31);
            do_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), ra, rb, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
